piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out transmitter: accepts one DATA_W-bit word per valid/ready handshake and
//  emits it one bit per consumed beat on ser_o, paced by a downstream bit-enable (shift_en_i).
//  It is the transmit end of the single-bit link whose receiver captures ser_o into enabled
//  1-bit registers. It sits between a word-wide producer and a serial line or shift-chain.
// PARAMETERS
//  DATA_W     8   word width in bits, >= 2
//  MSB_FIRST  1   1: bit DATA_W-1 is sent first; 0: bit 0 is sent first
// PORTS
//  clk_i        in   1       single clock, all logic on posedge
//  rst_i        in   1       synchronous, active-high reset
//  data_i       in   DATA_W  word to send, sampled on accept
//  valid_i      in   1       producer has a word
//  ready_o      out  1       serializer can accept; accept = valid_i & ready_o
//  shift_en_i   in   1       downstream consumes the current bit this cycle
//  ser_o        out  1       current serial bit, meaningful when ser_valid_o=1
//  ser_valid_o  out  1       ser_o holds a valid bit
//  first_o      out  1       current bit is the first bit of the frame
//  last_o       out  1       current bit is the last bit of the frame
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge): state=IDLE, shift reg=0, bit count=0; ser_o=0, ser_valid_o=0,
//    first_o=0, last_o=0. ready_o=1 from the first cycle after reset. rst_i dominates all inputs.
//  - FSM: IDLE -> SHIFT on accept. SHIFT -> IDLE when the last bit is consumed and no new accept
//    occurs. SHIFT -> SHIFT (reload) when the last bit is consumed and a new accept occurs.
//  - Latency: the first bit appears on ser_o with ser_valid_o=1 in the cycle after accept.
//  - Frame length: FLEN = DATA_W bits. The bit counter runs 0..FLEN-1.
//    first_o = SHIFT & (cnt==0). last_o = SHIFT & (cnt==FLEN-1).
//  - In SHIFT with shift_en_i=1: advance to the next bit (cnt+1, shift by one).
//    In SHIFT with shift_en_i=0: hold ser_o, cnt and all flags unchanged. There is no timeout.
//  - ready_o = (state==IDLE) | (last_o & shift_en_i). This is a combinational path from
//    shift_en_i, and it gives zero-gap back-to-back frames.
//  - shift_en_i in IDLE is ignored. valid_i while not ready is ignored; data_i is not sampled.
//  - data_i is registered at accept. Changes on data_i afterwards do not affect the frame in flight.
//  - Reset mid-frame: the frame is dropped with no further bits. The next cycle is IDLE with
//    ready_o=1.
//  - DATA_W=2, shift_en_i held high: exactly two beats per frame; first_o and last_o never overlap.
// CONFIGURATION
//  Macro PISO_PARITY_EN.
//  - Defined: FLEN = DATA_W+1. After the data bits, one even-parity bit (^word) is appended, and
//    last_o marks the parity bit.
//  - Undefined: FLEN = DATA_W, with no parity logic or register.
// STRUCTURE
//  - Package piso_pkg:
//    - state enum {IDLE, SHIFT}
//    - function cnt_w(DATA_W) = $clog2(DATA_W+2), sized for FLEN with or without parity
//  - Sub-module piso_bit_counter: enabled up-counter with load-to-0 and terminal-count flag
//    (cnt==FLEN-1).
//  - Top level holds the FSM, the shift register, and the optional parity register.
// TESTING
//  1. Reset: rst_i=1 for 2 cycles with valid_i=1 -> no accept, ser_valid_o=0, ready_o=1 after release.
//  2. DATA_W=8, MSB_FIRST=1, data_i=8'hA5, shift_en_i=1 -> ser_o=1,0,1,0,0,1,0,1 on 8 cycles;
//     first_o on beat 0, last_o on beat 7.
//  3. Back-to-back: words 8'h01 then 8'h80, valid_i held -> 16 contiguous valid beats, ready_o
//     high only on beat 7, no idle gap.
//  4. Stall: shift_en_i=0 for 3 cycles at beat 3 -> ser_o, first_o and last_o held; frame completes
//     after 8 consumed beats.
//  5. Mid-frame reset at beat 4 of 8'hFF -> ser_valid_o=0 next cycle; the next word 8'h0F is sent
//     in full from beat 0.
//  6. PISO_PARITY_EN defined, 8'h07 -> 9 beats; beat 8 is parity=1 with last_o=1.
//     MSB_FIRST=0 with 8'h07 -> ser_o=1,1,1,0,0,0,0,0 then parity 1.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter.
// Holds the FSM state encodings and the bit-counter width helper.
// Imported by piso_serializer.
package piso_pkg;

    // FSM state encodings
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Counter width large enough for a frame of DATA_W data bits plus an
    // optional parity bit, so the same width works in both builds.
    function automatic int cnt_w(input int data_w);
        return $clog2(data_w + 2);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Beat counter for the serializer: enabled up-counter with synchronous clear-to-0.
// Latency: count updates on the clock after en_i/clr_i; tc_o is combinational from the count.
// Ports: clk_i, rst_i (sync, active-high), clr_i (load 0, wins over en_i), en_i,
//        cnt_o (current count), tc_o (cnt_o == FLEN-1).
module piso_bit_counter #(
    parameter int CNT_W = 4,
    parameter int FLEN  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == CNT_W'(FLEN - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: one DATA_W word per valid/ready accept, one bit per shift_en_i beat.
// Latency: first bit on ser_o the cycle after accept; frames run back-to-back with no gap.
// Backpressure: shift_en_i=0 holds the current bit; ready_o is high in IDLE or while the last bit is consumed.
// Ports: clk_i, rst_i (sync, active-high), data_i/valid_i/ready_o (word input),
//        shift_en_i (downstream beat enable), ser_o/ser_valid_o/first_o/last_o (serial output).
// Build option: define PISO_PARITY_EN to append an even-parity bit (^word) after the data bits.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              shift_en_i,
    output logic              ser_o,
    output logic              ser_valid_o,
    output logic              first_o,
    output logic              last_o
);

    localparam int CNT_W = cnt_w(DATA_W);
`ifdef PISO_PARITY_EN
    localparam int FLEN = DATA_W + 1;
`else
    localparam int FLEN = DATA_W;
`endif

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [CNT_W-1:0]  cnt;
    logic              tc;
    logic              in_shift;
    logic              beat;
    logic              frame_done;
    logic              accept;
    logic              data_bit;

    assign in_shift   = (state_q == SHIFT);
    assign beat       = in_shift & shift_en_i;
    assign frame_done = beat & tc;

    // Accepting while the last bit is consumed lets the next frame start on
    // the following cycle. Reset masks ready so nothing is taken during it.
    assign ready_o = ~rst_i & (~in_shift | frame_done);
    assign accept  = valid_i & ready_o;

    assign data_bit = (MSB_FIRST != 0) ? shreg_q[DATA_W-1] : shreg_q[0];

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        if (accept) begin
            state_d = SHIFT;
            shreg_d = data_i;
        end else begin
            if (frame_done) begin
                state_d = IDLE;
            end
            if (beat) begin
                if (MSB_FIRST != 0) begin
                    shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                end else begin
                    shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    // Restart at 0 on a new word or at the end of a frame, so IDLE always
    // sees a zero count.
    piso_bit_counter #(
        .CNT_W (CNT_W),
        .FLEN  (FLEN)
    ) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (accept | frame_done),
        .en_i  (beat),
        .cnt_o (cnt),
        .tc_o  (tc)
    );

`ifdef PISO_PARITY_EN
    logic parity_q;
    logic parity_d;

    always_comb begin
        parity_d = parity_q;
        if (accept) begin
            parity_d = ^data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    // Once the data bits are exhausted the parity bit takes over the line.
    assign ser_o = in_shift & ((cnt == CNT_W'(DATA_W)) ? parity_q : data_bit);
`else
    assign ser_o = in_shift & data_bit;
`endif

    assign ser_valid_o = in_shift;
    assign first_o     = in_shift & (cnt == '0);
    assign last_o      = in_shift & tc;

endmodule
